// File: rtl/ctrl_pkg.sv
// Shared types and helpers for the controller event queue: button indices,
// event encoding and one-hot decoding.
package ctrl_pkg;

  localparam int unsigned BTN_W        = 10;
  localparam int unsigned BTN_CIRCLE   = 0;
  localparam int unsigned BTN_CROSS    = 1;
  localparam int unsigned BTN_SQUARE   = 2;
  localparam int unsigned BTN_TRIANGLE = 3;
  localparam int unsigned BTN_LEFT     = 4;
  localparam int unsigned BTN_RIGHT    = 5;
  localparam int unsigned BTN_UP       = 6;
  localparam int unsigned BTN_DOWN     = 7;
  localparam int unsigned BTN_R1       = 8;
  localparam int unsigned BTN_START    = 9;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned EVENT_W = 5;

  typedef struct packed {
    logic              player;
    logic [CODE_W-1:0] code;
  } event_t;

  function automatic logic is_onehot(input logic [BTN_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Code is bit index + 1; zero means "no valid button".
  function automatic logic [CODE_W-1:0] onehot_to_code(input logic [BTN_W-1:0] v);
    logic [CODE_W-1:0] c;
    c = '0;
    if (is_onehot(v)) begin
      for (int i = 0; i < BTN_W; i++) begin
        if (v[i]) c = CODE_W'(i + 1);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/controller_event_queue_if.sv
// Consumer-facing event handshake: show-ahead head of the event FIFO.
interface controller_event_queue_if;
  import ctrl_pkg::*;

  logic              ev_valid;
  logic              ev_ready;
  logic              ev_player;
  logic [CODE_W-1:0] ev_code;

  modport master (output ev_valid, output ev_player, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_player, input ev_code, output ev_ready);
endinterface

// File: rtl/event_fifo.sv
// Show-ahead event FIFO; a push while full is accepted only alongside a pop.
module event_fifo
  import ctrl_pkg::*;
#(
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  event_t        wdata_i,
  output event_t        rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [PtrW:0] count_o
);

  event_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(Depth));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  // Head reads as zero while empty so the outputs are clean after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PtrW+1)'(do_push) - (PtrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/controller_event_queue.sv
// Turns controller button changes into {player, code} events, arbitrates the two
// players' pending slots and queues events for the game logic.
module controller_event_queue
  import ctrl_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [BTN_W-1:0]          c1_i,
  input  logic [BTN_W-1:0]          c2_i,
  controller_event_queue_if.master  ev,
  output logic [$clog2(Depth):0]    ev_count_o,
  output logic [1:0]                overrun_o
);

  logic [1:0][BTN_W-1:0]  cur, prev_q;
  logic [1:0]             slot_valid_q, slot_valid_d;
  logic [1:0][CODE_W-1:0] slot_code_q, slot_code_d;
  logic [1:0]             overrun_q, overrun_d;
  logic                   tie_last_q, tie_last_d;
  logic                   push, pop, full, empty, grant;
  logic [1:0]             drained;
  event_t                 wdata, rdata;

  assign cur = {c2_i, c1_i};
  assign pop = ev.ev_ready && !empty;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_code_d  = slot_code_q;
    overrun_d    = overrun_q;
    tie_last_d   = tie_last_q;
    drained      = '0;

    // Round-robin state only advances on contested grants.
    grant = slot_valid_q[1] & ~slot_valid_q[0];
    if (&slot_valid_q) grant = ~tie_last_q;
    push = (|slot_valid_q) && (!full || pop);
    if (push && (&slot_valid_q)) tie_last_d = grant;
    if (push) drained[grant] = 1'b1;

    wdata.player = grant;
    wdata.code   = slot_code_q[grant];

    for (int p = 0; p < 2; p++) begin
      if (drained[p]) slot_valid_d[p] = 1'b0;
      if ((cur[p] != prev_q[p]) && is_onehot(cur[p])) begin
        slot_valid_d[p] = 1'b1;
        slot_code_d[p]  = onehot_to_code(cur[p]);
        if (slot_valid_q[p] && !drained[p]) overrun_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q       <= '0;
      slot_valid_q <= '0;
      slot_code_q  <= '0;
      overrun_q    <= '0;
      tie_last_q   <= 1'b1;
    end else begin
      prev_q       <= cur;
      slot_valid_q <= slot_valid_d;
      slot_code_q  <= slot_code_d;
      overrun_q    <= overrun_d;
      tie_last_q   <= tie_last_d;
    end
  end

  event_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (ev_count_o)
  );

  assign ev.ev_valid  = !empty;
  assign ev.ev_player = rdata.player;
  assign ev.ev_code   = rdata.code;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_controller_event_queue.sv
// Bench for controller_event_queue: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_controller_event_queue;
  import ctrl_pkg::*;

  localparam int unsigned Depth = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [9:0]             c1 = '0;
  logic [9:0]             c2 = '0;
  logic [$clog2(Depth):0] ev_count;
  logic [1:0]             overrun;

  controller_event_queue_if ev_if ();

  controller_event_queue #(
    .Depth (Depth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .c1_i       (c1),
    .c2_i       (c2),
    .ev         (ev_if.master),
    .ev_count_o (ev_count),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model state (current) and next-state copies.
  event_t     mq[$], nq[$];
  logic [9:0] mprev[2], nprev[2];
  bit         mslot_v[2], nslot_v[2];
  int         mslot_c[2], nslot_c[2];
  bit         mtie_p2, ntie_p2;
  bit [1:0]   movr, novr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int p = 0; p < 2; p++) begin
      mprev[p] = '0; mslot_v[p] = 1'b0; mslot_c[p] = 0;
    end
    mtie_p2 = 1'b1;
    movr    = '0;
  endtask

  // Apply inputs and predict the state after the next rising edge.
  task automatic drive(input logic [9:0] a, input logic [9:0] b, input bit rdy);
    logic [9:0] in_v[2];
    bit         pop, can;
    int         win;
    event_t     e;
    c1 = a; c2 = b; ev_if.ev_ready = rdy;
    in_v[0] = a; in_v[1] = b;
    nq = mq; nprev = mprev; nslot_v = mslot_v; nslot_c = mslot_c;
    ntie_p2 = mtie_p2; novr = movr;
    pop = rdy && (mq.size() != 0);
    can = (mq.size() < Depth) || pop;
    if (pop) void'(nq.pop_front());
    win = -1;
    if (mslot_v[0] && mslot_v[1]) win = mtie_p2 ? 0 : 1;
    else if (mslot_v[0])          win = 0;
    else if (mslot_v[1])          win = 1;
    if (can && win >= 0) begin
      e.player = (win == 1);
      e.code   = 4'(mslot_c[win]);
      nq.push_back(e);
      nslot_v[win] = 1'b0;
      if (mslot_v[0] && mslot_v[1]) ntie_p2 = (win == 1);
    end
    for (int p = 0; p < 2; p++) begin
      if (in_v[p] != mprev[p] && $countones(in_v[p]) == 1) begin
        if (nslot_v[p]) novr[p] = 1'b1;
        nslot_v[p] = 1'b1;
        nslot_c[p] = $clog2(in_v[p]) + 1;
      end
      nprev[p] = in_v[p];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mq = nq; mprev = nprev; mslot_v = nslot_v; mslot_c = nslot_c;
    mtie_p2 = ntie_p2; movr = novr;
  endtask

  task automatic cycle(input logic [9:0] a, input logic [9:0] b, input bit rdy);
    drive(a, b, rdy);
    step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1; c1 = '0; c2 = '0; ev_if.ev_ready = 1'b0;
    #1;
    chk("rst_ev_valid", ev_if.ev_valid, 1'b0);
    chk("rst_ev_count", ev_count, 0);
    chk("rst_overrun", overrun, 2'b00);
    chk("rst_ev_code", ev_if.ev_code, 4'd0);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ev_valid", ev_if.ev_valid, mq.size() != 0);
      chk("ev_count", ev_count, mq.size());
      chk("overrun", overrun, movr);
      if (mq.size() != 0) begin
        chk("ev_player", ev_if.ev_player, mq[0].player);
        chk("ev_code", ev_if.ev_code, mq[0].code);
      end
    end
  end

  initial begin
    logic [9:0] r1, r2;
    ev_if.ev_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("init_ev_valid", ev_if.ev_valid, 1'b0);
    chk("init_ev_player", ev_if.ev_player, 1'b0);
    chk("init_ev_code", ev_if.ev_code, 4'd0);
    chk("init_ev_count", ev_count, 0);
    chk("init_overrun", overrun, 2'b00);
    rst = 1'b0;
    chk_en = 1'b1;

    // First event: two edges of latency.
    cycle(10'h004, 10'h000, 1'b0);
    chk("lat_valid_early", ev_if.ev_valid, 1'b0);
    cycle(10'h004, 10'h000, 1'b0);
    chk("lat_valid", ev_if.ev_valid, 1'b1);
    chk("lat_player", ev_if.ev_player, 1'b0);
    chk("lat_code", ev_if.ev_code, 4'd3);
    cycle(10'h004, 10'h000, 1'b1);
    chk("lat_pop_count", ev_count, 0);

    // Tie: P1 first, then P2; the next tie goes to P2.
    cycle(10'h001, 10'h200, 1'b1);
    cycle(10'h001, 10'h200, 1'b1);
    chk("tie1_player", ev_if.ev_player, 1'b0);
    chk("tie1_code", ev_if.ev_code, 4'd1);
    cycle(10'h001, 10'h200, 1'b1);
    chk("tie1b_player", ev_if.ev_player, 1'b1);
    chk("tie1b_code", ev_if.ev_code, 4'd10);
    cycle(10'h001, 10'h200, 1'b1);
    cycle(10'h002, 10'h100, 1'b1);
    cycle(10'h002, 10'h100, 1'b1);
    chk("tie2_player", ev_if.ev_player, 1'b1);
    chk("tie2_code", ev_if.ev_code, 4'd9);
    cycle(10'h002, 10'h100, 1'b1);
    chk("tie2b_player", ev_if.ev_player, 1'b0);
    chk("tie2b_code", ev_if.ev_code, 4'd2);
    cycle(10'h002, 10'h100, 1'b1);

    // Fill the FIFO, park one in the slot, then overwrite it.
    for (int i = 0; i < 9; i++) cycle(10'(1 << i), 10'h100, 1'b0);
    cycle(10'h100, 10'h100, 1'b0);
    chk("full_count", ev_count, Depth);
    chk("full_head", ev_if.ev_code, 4'd1);
    chk("full_ovr", overrun, 2'b00);
    cycle(10'h200, 10'h100, 1'b0);
    chk("ovr_set", overrun, 2'b01);
    cycle(10'h200, 10'h100, 1'b1);
    chk("fullpp_count", ev_count, Depth);
    chk("fullpp_head", ev_if.ev_code, 4'd2);
    repeat (10) cycle(10'h200, 10'h100, 1'b1);
    chk("drained_count", ev_count, 0);

    // Multi-hot produces no event; a long hold produces nothing more.
    cycle(10'h200, 10'h010, 1'b1);
    cycle(10'h200, 10'h030, 1'b1);
    cycle(10'h200, 10'h010, 1'b1);
    repeat (1000) cycle(10'h200, 10'h010, 1'b1);
    chk("hold_count", ev_count, 0);

    // Reset with events queued.
    for (int i = 0; i < 5; i++) cycle(10'(1 << i), 10'h010, 1'b0);
    cycle(10'h010, 10'h010, 1'b0);
    chk("pre_rst_count", ev_count, 5);
    pulse_reset();
    repeat (5) cycle(10'h000, 10'h000, 1'b1);
    chk("post_rst_valid", ev_if.ev_valid, 1'b0);

    // Randomized traffic.
    r1 = '0; r2 = '0;
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 20 : ((blk % 3 == 1) ? 60 : 95);
      for (int k = 0; k < 100; k++) begin
        for (int p = 0; p < 2; p++) begin
          logic [9:0] v;
          int         sel;
          v   = (p == 0) ? r1 : r2;
          sel = $urandom_range(0, 9);
          if (sel >= 4 && sel <= 6) v = 10'(1 << $urandom_range(0, 9));
          else if (sel == 7)        v = '0;
          else if (sel >= 8)        v = 10'($urandom);
          if (p == 0) r1 = v; else r2 = v;
        end
        cycle(r1, r2, $urandom_range(0, 99) < rdy_pct);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
